ps2_host_tx: RTL and testbench

//  PS/2 host-to-device transmitter; the opposite direction to the keyboard receiver.

---
 rtl/ps2_host_tx.sv | 204 ++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 11-clock frame, ack check, watchdog.
// Define PS2_TX_RETRY_EN to re-send a failed byte once before reporting ack_err/timeout.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int TIMEOUT_CYCLES = 400000,
  parameter int FILTER_LEN     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2clk_in,
  input  logic       ps2data_in,
  output logic       ps2clk_oe,
  output logic       ps2data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout
);
  localparam int IW = $clog2(INHIBIT_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int FW = $clog2(FILTER_LEN);
`ifdef PS2_TX_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_DATA, S_PARITY, S_STOP, S_ACK_OK, S_WAIT_IDLE
  } state_t;

  state_t        r_state, w_state_nx;
  logic [1:0]    r_clk_s, r_dat_s;
  logic          r_clk_f;
  logic [FW-1:0] r_fcnt;
  logic [7:0]    r_byte, w_byte_nx;
  logic          r_par, w_par_nx;
  logic [2:0]    r_bitcnt, w_bitcnt_nx, w_bitnx;
  logic [IW-1:0] r_icnt, w_icnt_nx;
  logic [TW-1:0] r_wdog, w_wdog_nx;
  logic          r_clk_oe, w_clk_oe_nx, r_dat_oe, w_dat_oe_nx;
  logic          r_done, w_done_nx, r_ackerr, w_ackerr_nx, r_tmo, w_tmo_nx;
  logic          r_retry, w_retry_nx, r_redo, w_redo_nx;
  logic          w_fall, w_active, w_tmo_hit, w_can_retry, w_restart;

  // Filtered clock flips only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_s <= 2'b11;
      r_dat_s <= 2'b11;
      r_clk_f <= 1'b1;
      r_fcnt  <= '0;
    end else begin
      r_clk_s <= {r_clk_s[0], ps2clk_in};
      r_dat_s <= {r_dat_s[0], ps2data_in};
      if (r_clk_s[1] == r_clk_f) r_fcnt <= '0;
      else if (r_fcnt == FW'(FILTER_LEN-1)) begin
        r_clk_f <= r_clk_s[1];
        r_fcnt  <= '0;
      end else r_fcnt <= r_fcnt + 1'b1;
    end
  end

  assign w_fall      = r_clk_f & ~r_clk_s[1] & (r_fcnt == FW'(FILTER_LEN-1));
  assign w_active    = r_state inside {S_REQ, S_DATA, S_PARITY, S_STOP, S_ACK_OK, S_WAIT_IDLE};
  assign w_tmo_hit   = w_active && (r_wdog == TW'(TIMEOUT_CYCLES-1));
  assign w_can_retry = RETRY & ~r_retry;
  assign w_bitnx     = r_bitcnt + 3'd1;

  always_comb begin
    w_state_nx  = r_state;
    w_byte_nx   = r_byte;
    w_par_nx    = r_par;
    w_bitcnt_nx = r_bitcnt;
    w_icnt_nx   = r_icnt;
    w_wdog_nx   = (w_fall || !w_active) ? '0 : r_wdog + 1'b1;
    w_clk_oe_nx = r_clk_oe;
    w_dat_oe_nx = r_dat_oe;
    w_done_nx   = 1'b0;
    w_ackerr_nx = 1'b0;
    w_tmo_nx    = 1'b0;
    w_retry_nx  = r_retry;
    w_redo_nx   = r_redo;
    w_restart   = 1'b0;
    case (r_state)
      S_IDLE: if (tx_valid) begin
        w_byte_nx   = tx_data;
        w_par_nx    = ~^tx_data;
        w_bitcnt_nx = '0;
        w_icnt_nx   = '0;
        w_clk_oe_nx = 1'b1;
        w_retry_nx  = 1'b0;
        w_redo_nx   = 1'b0;
        w_state_nx  = S_INHIBIT;
      end
      S_INHIBIT: begin
        w_icnt_nx = r_icnt + 1'b1;
        if (r_icnt == IW'(INHIBIT_CYCLES-2)) w_dat_oe_nx = 1'b1;
        if (r_icnt == IW'(INHIBIT_CYCLES-1)) begin
          w_clk_oe_nx = 1'b0;
          w_state_nx  = S_REQ;
        end
      end
      S_REQ: if (w_fall) begin
        w_dat_oe_nx = ~r_byte[0];
        w_bitcnt_nx = '0;
        w_state_nx  = S_DATA;
      end
      S_DATA: if (w_fall) begin
        if (r_bitcnt == 3'd7) begin
          w_dat_oe_nx = ~r_par;
          w_state_nx  = S_PARITY;
        end else begin
          w_bitcnt_nx = w_bitnx;
          w_dat_oe_nx = ~r_byte[w_bitnx];
        end
      end
      S_PARITY: if (w_fall) begin
        w_dat_oe_nx = 1'b0;
        w_state_nx  = S_STOP;
      end
      S_STOP: if (w_fall) begin
        if (!r_dat_s[1]) w_state_nx = S_ACK_OK;
        else begin
          w_state_nx = S_WAIT_IDLE;
          if (w_can_retry) w_redo_nx = 1'b1;
          else w_ackerr_nx = 1'b1;
        end
      end
      S_ACK_OK, S_WAIT_IDLE: if (r_clk_f && r_dat_s[1]) begin
        if (r_redo) w_restart = 1'b1;
        else begin
          w_done_nx  = (r_state == S_ACK_OK);
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
    // Watchdog wins over anything decided above in the same cycle
    if (w_tmo_hit) begin
      w_done_nx   = 1'b0;
      w_ackerr_nx = 1'b0;
      if (w_can_retry) w_restart = 1'b1;
      else begin
        w_clk_oe_nx = 1'b0;
        w_dat_oe_nx = 1'b0;
        w_tmo_nx    = 1'b1;
        w_state_nx  = S_IDLE;
      end
    end
    if (w_restart) begin
      w_state_nx  = S_INHIBIT;
      w_clk_oe_nx = 1'b1;
      w_dat_oe_nx = 1'b0;
      w_icnt_nx   = '0;
      w_bitcnt_nx = '0;
      w_redo_nx   = 1'b0;
      w_retry_nx  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_byte   <= '0;
      r_par    <= 1'b0;
      r_bitcnt <= '0;
      r_icnt   <= '0;
      r_wdog   <= '0;
      r_clk_oe <= 1'b0;
      r_dat_oe <= 1'b0;
      r_done   <= 1'b0;
      r_ackerr <= 1'b0;
      r_tmo    <= 1'b0;
      r_retry  <= 1'b0;
      r_redo   <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_byte   <= w_byte_nx;
      r_par    <= w_par_nx;
      r_bitcnt <= w_bitcnt_nx;
      r_icnt   <= w_icnt_nx;
      r_wdog   <= w_wdog_nx;
      r_clk_oe <= w_clk_oe_nx;
      r_dat_oe <= w_dat_oe_nx;
      r_done   <= w_done_nx;
      r_ackerr <= w_ackerr_nx;
      r_tmo    <= w_tmo_nx;
      r_retry  <= w_retry_nx;
      r_redo   <= w_redo_nx;
    end
  end

  assign tx_ready   = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign ps2clk_oe  = r_clk_oe;
  assign ps2data_oe = r_dat_oe;
  assign done       = r_done;
  assign ack_err    = r_ackerr;
  assign timeout    = r_tmo;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model.
module tb_ps2_host_tx;
  localparam int INH = 20, TMO = 200, FLT = 4, HP = 12;

  logic       clk = 1'b0, reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2clk_oe, ps2data_oe, busy, done, ack_err, timeout;
  logic       dev_clk = 1'b1, dev_dat = 1'b1;
  logic       ps2clk_in, ps2data_in;

  assign ps2clk_in  = dev_clk & ~ps2clk_oe;
  assign ps2data_in = dev_dat & ~ps2data_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .FILTER_LEN(FLT)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ps2clk_in(ps2clk_in), .ps2data_in(ps2data_in), .ps2clk_oe(ps2clk_oe), .ps2data_oe(ps2data_oe),
    .busy(busy), .done(done), .ack_err(ack_err), .timeout(timeout));

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;
  int n_done = 0, n_ack = 0, n_tmo = 0;
  always @(posedge clk) begin
    if (done)    n_done <= n_done + 1;
    if (ack_err) n_ack  <= n_ack + 1;
    if (timeout) n_tmo  <= n_tmo + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] pulses(input int d0, input int a0, input int t0);
    return {8'(n_done - d0), 8'(n_ack - a0), 8'(n_tmo - t0)};
  endfunction

  // Request a byte and measure the inhibit phase; optionally pokes 0x55 while busy
  task automatic send(input logic [7:0] b, input bit inject, input string tag);
    int cnt;
    logic fd, ld;
    chk({tag, " ready"}, 32'(tx_ready), 1);
    @(negedge clk); tx_data = b; tx_valid = 1'b1;
    @(negedge clk); tx_valid = 1'b0;
    cnt = 0; fd = 1'b1; ld = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      if (!ps2clk_oe) break;
      if (cnt == 0) fd = ps2data_oe;
      ld = ps2data_oe;
      cnt++;
      if (inject && cnt == 5) begin tx_data = 8'h55; tx_valid = 1'b1; end
      else tx_valid = 1'b0;
      @(negedge clk);
    end
    tx_valid = 1'b0;
    chk({tag, " inhibit len"}, 32'(cnt), INH);
    chk({tag, " start/req"}, {29'(0), fd, ld, ps2data_oe}, 32'b011);
  endtask

  task automatic dev_frame(input int nclk, input bit ack, input string tag, output logic [9:0] bits);
    bit ok = 1'b0;
    bits = '0;
    for (int k = 0; k < 1000; k++) begin
      if (busy && !ps2clk_oe && ps2data_oe) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk({tag, " req seen"}, 32'(ok), 1);
    if (!ok) return;
    for (int i = 0; i < nclk; i++) begin
      if (i == 10 && ack) dev_dat = 1'b0;
      repeat (HP) @(negedge clk);
      dev_clk = 1'b0;
      repeat (HP) @(negedge clk);
      dev_clk = 1'b1;
      if (i < 10) bits[i] = ps2data_in;
    end
    repeat (HP) @(negedge clk);
    dev_dat = 1'b1;
  endtask

  task automatic xfer(input logic [7:0] b, input bit ack, input bit inject,
                      input logic [9:0] exp_bits, input logic [23:0] exp_p, input string tag);
    int d0, a0, t0, k;
    logic [9:0] bits;
    d0 = n_done; a0 = n_ack; t0 = n_tmo;
    send(b, inject, tag);
    dev_frame(11, ack, tag, bits);
    chk({tag, " frame"}, 32'(bits), 32'(exp_bits));
    for (k = 0; k < 1000 && busy; k++) @(negedge clk);
    chk({tag, " idle"}, 32'(busy), 0);
    repeat (3) @(negedge clk);
    chk({tag, " pulses"}, 32'(pulses(d0, a0, t0)), 32'(exp_p));
    chk({tag, " ready after"}, {30'(0), tx_ready, ps2clk_oe | ps2data_oe}, 32'b10);
  endtask

  initial begin
    int d0, a0, t0, n;
    logic [9:0] bits;
    repeat (3) @(negedge clk);
    chk("reset state", {25'(0), ps2clk_oe, ps2data_oe, tx_ready, busy, done, ack_err, timeout}, 32'b0010000);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    xfer(8'hED, 1'b1, 1'b0, 10'h3ED, 24'h010000, "t1 ED");
    xfer(8'h00, 1'b1, 1'b0, 10'h300, 24'h010000, "t2 00");
    xfer(8'h01, 1'b1, 1'b0, 10'h201, 24'h010000, "t2 01");
    xfer(8'hFF, 1'b0, 1'b0, 10'h3FF, 24'h000100, "t3 nack");

    // Device stays silent after the request
    d0 = n_done; a0 = n_ack; t0 = n_tmo;
    send(8'h12, 1'b0, "t4");
    n = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      n++;
      if (timeout) break;
    end
    chk("t4 timeout latency", 32'(n), TMO);
    chk("t4 released", {29'(0), ps2clk_oe, ps2data_oe, busy}, 0);
    repeat (3) @(negedge clk);
    chk("t4 pulses", 32'(pulses(d0, a0, t0)), 32'h000001);

    // Reset after the 4th data bit
    d0 = n_done; a0 = n_ack; t0 = n_tmo;
    send(8'hA5, 1'b0, "t5");
    dev_frame(4, 1'b1, "t5", bits);
    chk("t5 mid busy", 32'(busy), 1);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    chk("t5 after reset", {25'(0), ps2clk_oe, ps2data_oe, tx_ready, busy, done, ack_err, timeout}, 32'b0010000);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    chk("t5 pulses", 32'(pulses(d0, a0, t0)), 0);

    xfer(8'h3C, 1'b1, 1'b1, 10'h33C, 24'h010000, "t6 ignore");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
